// File: rtl/flag_tracker.sv
// Flag slot store for one rally level: ROM load, collection by the player car, and per-pixel flag mask.
// The last remaining flag blinks. The win flag holds until the next level start.
module flag_tracker #(
  parameter int MAX_FLAGS  = 8,
  parameter int COORD_W    = 10,
  parameter int CELL_LOG2  = 5,
  parameter int BLINK_LOG2 = 4,
  localparam int IDX_W  = (MAX_FLAGS > 1) ? $clog2(MAX_FLAGS) : 1,
  localparam int GRID_W = COORD_W - CELL_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            level_id,
  input  logic                  level_start,
  output logic [IDX_W+1:0]      rom_addr,
  input  logic [2*GRID_W:0]     rom_data,
  input  logic [COORD_W-1:0]    player_x,
  input  logic [COORD_W-1:0]    player_y,
  input  logic [COORD_W-1:0]    vga_x,
  input  logic [COORD_W-1:0]    vga_y,
  input  logic                  frame_tick,
  output logic                  flag_pixel,
  output logic                  collect_pulse,
  output logic [IDX_W:0]        flags_left,
  output logic                  all_collected,
  output logic                  busy
);

  localparam int CNT_W = IDX_W + 1;
  localparam int SH_L  = (CELL_LOG2 >= 5) ? CELL_LOG2 - 5 : 0;
  localparam int SH_R  = (CELL_LOG2 < 5) ? 5 - CELL_LOG2 : 0;

  // Shape constants are drawn for a 32-pixel cell and rescaled to the real cell size.
  function automatic logic [31:0] sc(input int c);
    return (32'(c) << SH_L) >> SH_R;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t                state, state_nx;
  logic [1:0]            level_q;
  logic [CNT_W-1:0]      ctr;
  logic [CNT_W-1:0]      wr_idx;
  logic [MAX_FLAGS-1:0]  valid, collected, hit, draw;
  logic [GRID_W-1:0]     pos_gx [MAX_FLAGS];
  logic [GRID_W-1:0]     pos_gy [MAX_FLAGS];
  logic [CNT_W-1:0]      hit_cnt;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  blink_phase;
  logic [31:0]           lx, ly;
  logic                  shape;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (level_start) begin
      state_nx = LOAD;
    end else if (state == LOAD && ctr == CNT_W'(MAX_FLAGS)) begin
      state_nx = PLAY;
    end
  end

  assign wr_idx = ctr - CNT_W'(1);

  always_comb begin
    hit     = '0;
    draw    = '0;
    hit_cnt = '0;
    for (int i = 0; i < MAX_FLAGS; i++) begin
      hit[i]  = valid[i] & ~collected[i] &
                (pos_gx[i] == player_x[COORD_W-1:CELL_LOG2]) &
                (pos_gy[i] == player_y[COORD_W-1:CELL_LOG2]);
      draw[i] = valid[i] & ~collected[i] &
                (pos_gx[i] == vga_x[COORD_W-1:CELL_LOG2]) &
                (pos_gy[i] == vga_y[COORD_W-1:CELL_LOG2]);
      hit_cnt = hit_cnt + CNT_W'(hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q       <= '0;
      ctr           <= '0;
      valid         <= '0;
      collected     <= '0;
      flags_left    <= '0;
      collect_pulse <= 1'b0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b1;
      for (int i = 0; i < MAX_FLAGS; i++) begin
        pos_gx[i] <= '0;
        pos_gy[i] <= '0;
      end
    end else begin
      collect_pulse <= 1'b0;
      if (frame_tick) begin
        blink_cnt <= blink_cnt + BLINK_LOG2'(1);
        if (&blink_cnt) blink_phase <= ~blink_phase;
      end
      if (level_start) begin
        level_q     <= level_id;
        valid       <= '0;
        collected   <= '0;
        flags_left  <= '0;
        ctr         <= '0;
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (state == LOAD) begin
        // rom_data answers the address issued last cycle, so it belongs to slot ctr-1.
        if (ctr != '0) begin
          for (int i = 0; i < MAX_FLAGS; i++) begin
            if (wr_idx == CNT_W'(i)) begin
              valid[i]  <= rom_data[2*GRID_W];
              pos_gx[i] <= rom_data[2*GRID_W-1:GRID_W];
              pos_gy[i] <= rom_data[GRID_W-1:0];
            end
          end
          flags_left <= flags_left + CNT_W'(rom_data[2*GRID_W]);
        end
        if (ctr != CNT_W'(MAX_FLAGS)) ctr <= ctr + CNT_W'(1);
      end else if (state == PLAY) begin
        collected     <= collected | hit;
        flags_left    <= flags_left - hit_cnt;
        collect_pulse <= |hit;
      end
    end
  end

  assign lx = 32'(vga_x[CELL_LOG2-1:0]);
  assign ly = 32'(vga_y[CELL_LOG2-1:0]);

  always_comb begin
    shape = 1'b0;
    if (lx >= sc(5) && lx <= sc(7) && ly >= sc(4) && ly <= sc(28)) shape = 1'b1;
    if (lx > sc(7) && ly >= sc(4) && ly <= sc(16) && (lx + ly) <= (sc(26) + sc(4))) shape = 1'b1;
  end

  assign flag_pixel    = (state == PLAY) && shape && (|draw) &&
                         !(flags_left == CNT_W'(1) && !blink_phase);
  assign all_collected = (state == PLAY) && (flags_left == '0) && (|valid);
  assign busy          = (state == LOAD);
  assign rom_addr      = (state == LOAD) ? {level_q, ctr[IDX_W-1:0]} : '0;

endmodule

// File: tb/tb_flag_tracker.sv
// Directed bench for flag_tracker with a 1-cycle-latency level ROM model.
module tb_flag_tracker;
  logic        clk = 1'b0;
  logic        rst, level_start, frame_tick;
  logic [1:0]  level_id;
  logic [4:0]  rom_addr;
  logic [10:0] rom_data;
  logic [9:0]  player_x, player_y, vga_x, vga_y;
  logic        flag_pixel, collect_pulse, all_collected, busy;
  logic [3:0]  flags_left;
  logic [10:0] rom_mem [0:31];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  flag_tracker dut (
    .clk(clk), .rst(rst), .level_id(level_id), .level_start(level_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .player_x(player_x), .player_y(player_y), .vga_x(vga_x), .vga_y(vga_y),
    .frame_tick(frame_tick), .flag_pixel(flag_pixel), .collect_pulse(collect_pulse),
    .flags_left(flags_left), .all_collected(all_collected), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] lvl, output int cycles);
    level_id = lvl;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (rom_addr !== 5'd0) begin n_err++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    n_cmp++; if (flag_pixel !== 1'b0) begin n_err++; $display("FAIL reset_flag_pixel got %b want 0", flag_pixel); end
    n_cmp++; if (collect_pulse !== 1'b0) begin n_err++; $display("FAIL reset_collect_pulse got %b want 0", collect_pulse); end
    n_cmp++; if (flags_left !== 4'd0) begin n_err++; $display("FAIL reset_flags_left got %0d want 0", flags_left); end
    n_cmp++; if (all_collected !== 1'b0) begin n_err++; $display("FAIL reset_all_collected got %b want 0", all_collected); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    int cyc;
    level_id = 2'd1;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    n_cmp++; if (rom_addr !== 5'd8) begin n_err++; $display("FAIL load_first_addr got %0d want 8", rom_addr); end
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL load_busy_cycles got %0d want 9", cyc); end
    n_cmp++; if (flags_left !== 4'd2) begin n_err++; $display("FAIL load_flags_left got %0d want 2", flags_left); end
    n_cmp++; if (all_collected !== 1'b0) begin n_err++; $display("FAIL load_all_collected got %b want 0", all_collected); end
  endtask

  task automatic test_shape;
    logic [9:0] xs [4] = '{10'd581, 10'd586, 10'd596, 10'd579};
    logic [9:0] ys [4] = '{10'd356, 10'd362, 10'd366, 10'd362};
    logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      vga_x = xs[i];
      vga_y = ys[i];
      #1;
      n_cmp++; if (flag_pixel !== exp[i]) begin n_err++; $display("FAIL shape_%0d got %b want %b", i, flag_pixel, exp[i]); end
    end
  endtask

  task automatic test_collect;
    vga_x = 10'd581; vga_y = 10'd356;
    player_x = 10'd580; player_y = 10'd356;
    tick();
    n_cmp++; if (collect_pulse !== 1'b1) begin n_err++; $display("FAIL collect_pulse got %b want 1", collect_pulse); end
    n_cmp++; if (flags_left !== 4'd1) begin n_err++; $display("FAIL collect_flags_left got %0d want 1", flags_left); end
    n_cmp++; if (flag_pixel !== 1'b0) begin n_err++; $display("FAIL collect_pixel_gone got %b want 0", flag_pixel); end
    tick();
    n_cmp++; if (collect_pulse !== 1'b0) begin n_err++; $display("FAIL collect_pulse_once got %b want 0", collect_pulse); end
    player_x = 10'd0; player_y = 10'd0;
  endtask

  task automatic test_blink;
    vga_x = 10'd229; vga_y = 10'd68;
    #1;
    n_cmp++; if (flag_pixel !== 1'b1) begin n_err++; $display("FAIL blink_initial got %b want 1", flag_pixel); end
    for (int i = 1; i <= 32; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      if (i == 15 || i == 16 || i == 31 || i == 32) begin
        n_cmp++;
        if (flag_pixel !== ((i == 16 || i == 31) ? 1'b0 : 1'b1)) begin
          n_err++; $display("FAIL blink_after_%0d got %b", i, flag_pixel);
        end
      end
    end
  endtask

  task automatic test_win;
    player_x = 10'd230; player_y = 10'd70;
    tick();
    n_cmp++; if (flags_left !== 4'd0) begin n_err++; $display("FAIL win_flags_left got %0d want 0", flags_left); end
    n_cmp++; if (all_collected !== 1'b1) begin n_err++; $display("FAIL win_all_collected got %b want 1", all_collected); end
    n_cmp++; if (collect_pulse !== 1'b1) begin n_err++; $display("FAIL win_pulse got %b want 1", collect_pulse); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (collect_pulse !== 1'b0 || all_collected !== 1'b1) begin
        n_err++; $display("FAIL win_hold_%0d pulse %b won %b want 0/1", i, collect_pulse, all_collected);
      end
    end
    player_x = 10'd0; player_y = 10'd0;
  endtask

  task automatic test_same_cell;
    int cyc;
    do_load(2'd2, cyc);
    n_cmp++; if (flags_left !== 4'd2) begin n_err++; $display("FAIL same_cell_loaded got %0d want 2", flags_left); end
    player_x = 10'd291; player_y = 10'd259;
    tick();
    n_cmp++; if (flags_left !== 4'd0) begin n_err++; $display("FAIL same_cell_flags_left got %0d want 0", flags_left); end
    n_cmp++; if (collect_pulse !== 1'b1) begin n_err++; $display("FAIL same_cell_pulse got %b want 1", collect_pulse); end
    n_cmp++; if (all_collected !== 1'b1) begin n_err++; $display("FAIL same_cell_won got %b want 1", all_collected); end
    tick();
    n_cmp++; if (collect_pulse !== 1'b0) begin n_err++; $display("FAIL same_cell_single_pulse got %b want 0", collect_pulse); end
    player_x = 10'd0; player_y = 10'd0;
  endtask

  task automatic test_mid_load;
    int cyc;
    level_id = 2'd0;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    tick(); tick(); tick();
    level_id = 2'd2;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    n_cmp++; if (rom_addr !== 5'd16) begin n_err++; $display("FAIL restart_addr got %0d want 16", rom_addr); end
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL restart_busy_cycles got %0d want 9", cyc); end
    n_cmp++; if (flags_left !== 4'd2) begin n_err++; $display("FAIL restart_flags_left got %0d want 2", flags_left); end
  endtask

  task automatic test_start_priority;
    int cyc;
    player_x = 10'd291; player_y = 10'd259;
    level_id = 2'd2;
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    player_x = 10'd0; player_y = 10'd0;
    n_cmp++; if (collect_pulse !== 1'b0 || flags_left !== 4'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL start_priority pulse %b left %0d busy %b want 0/0/1", collect_pulse, flags_left, busy);
    end
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    n_cmp++; if (flags_left !== 4'd2) begin n_err++; $display("FAIL start_priority_reload got %0d want 2", flags_left); end
  endtask

  task automatic test_empty;
    int cyc;
    do_load(2'd3, cyc);
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL empty_busy_cycles got %0d want 9", cyc); end
    n_cmp++; if (flags_left !== 4'd0 || all_collected !== 1'b0) begin
      n_err++; $display("FAIL empty_state left %0d won %b want 0/0", flags_left, all_collected);
    end
    vga_x = 10'd293; vga_y = 10'd260;
    #1;
    n_cmp++; if (flag_pixel !== 1'b0) begin n_err++; $display("FAIL empty_pixel got %b want 0", flag_pixel); end
    player_x = 10'd291; player_y = 10'd259;
    tick();
    n_cmp++; if (collect_pulse !== 1'b0 || all_collected !== 1'b0) begin
      n_err++; $display("FAIL empty_no_collect pulse %b won %b want 0/0", collect_pulse, all_collected);
    end
    player_x = 10'd0; player_y = 10'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = 11'd0;
    for (int i = 0; i < 5; i++) rom_mem[i] = {1'b1, 5'(i + 1), 5'd1};
    rom_mem[8]  = {1'b1, 5'd18, 5'd11};
    rom_mem[9]  = {1'b1, 5'd7, 5'd2};
    rom_mem[16] = {1'b1, 5'd9, 5'd8};
    rom_mem[19] = {1'b1, 5'd9, 5'd8};
    for (int i = 24; i < 32; i++) rom_mem[i] = {1'b0, 5'd9, 5'd8};
    rst = 1'b1; level_start = 1'b0; frame_tick = 1'b0; level_id = 2'd0;
    player_x = 10'd0; player_y = 10'd0; vga_x = 10'd0; vga_y = 10'd0;
    test_reset();
    test_load();
    test_shape();
    test_collect();
    test_blink();
    test_win();
    test_same_cell();
    test_mid_load();
    test_start_priority();
    test_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/flag_tracker.md
# flag_tracker

Parametrised flag collection and rendering engine for the rally game. It holds up to `MAX_FLAGS` flag positions per level, loaded from an external level ROM when a level starts. Each cycle it collects flags the player car drives over, counts the flags remaining and raises the win condition. It also feeds a per-pixel flag mask to the VGA compositor, and the last remaining flag blinks.

## Interface
Parameters:
- `MAX_FLAGS`, 8: flag slots per level, 1..16. `IDX_W = clog2(MAX_FLAGS)`, minimum 1.
- `COORD_W`, 10: width of pixel coordinates.
- `CELL_LOG2`, 5: grid cell size is 2^CELL_LOG2 pixels (32). `GRID_W = COORD_W - CELL_LOG2`.
- `BLINK_LOG2`, 4: the blink phase toggles every 2^BLINK_LOG2 `frame_tick` pulses.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `level_id` in 2: current level. It is sampled on `level_start`.
- `level_start` in 1: one-cycle pulse that starts the ROM load for `level_id`.
- `rom_addr` out 2+IDX_W: `{level, slot}` address to the level ROM. The ROM has 1-cycle read latency.
- `rom_data` in 1+2·GRID_W: `{valid, gx, gy}` entry for the slot addressed in the previous cycle.
- `player_x`, `player_y` in COORD_W: player car position.
- `vga_x`, `vga_y` in COORD_W: pixel currently being drawn.
- `frame_tick` in 1: one-cycle pulse per frame.
- `flag_pixel` out 1: the current pixel belongs to an uncollected, visible flag.
- `collect_pulse` out 1: one-cycle pulse when one or more flags are collected.
- `flags_left` out IDX_W+1: count of valid flags not yet collected.
- `all_collected` out 1: level won.
- `busy` out 1: a ROM load is in progress.

## Operation
- Grid coordinates are `coord[COORD_W-1:CELL_LOG2]`. Local offset is `coord[CELL_LOG2-1:0]`.
- Per slot state:
  - `pos_gx`, `pos_gy`
  - `valid`
  - `collected`
- FSM states: IDLE, LOAD, PLAY.
  - IDLE (reset state): no flags, `all_collected=0`.
  - `level_start` in any state, including mid-LOAD:
    - latch `level_id`;
    - clear all `valid` and `collected`;
    - zero `flags_left`;
    - set slot counter to 0;
    - go to LOAD.
  - LOAD: `rom_addr={level,ctr}` for ctr = 0..MAX_FLAGS-1.
    - The data returned one cycle later is written to slot ctr-1.
    - `flags_left` increments for each entry with `valid=1`.
    - After the last slot is written, go to PLAY.
    - LOAD spans exactly MAX_FLAGS+1 cycles.
  - PLAY: each cycle, every slot with `valid & ~collected` and `pos == player grid` sets `collected`.
    - `flags_left` decreases by the number of slots hit in that cycle (popcount), so two flags in one cell are both collected.
    - `collect_pulse` is 1 in the cycle after the hit, once per hit cycle.
- `all_collected` = PLAY & `flags_left==0` & at least one valid flag loaded. It holds until the next `level_start` or `rst`.
- If a level has zero valid entries, the FSM enters PLAY with `all_collected` held at 0.
- Collection is disabled in IDLE and LOAD.
- Rendering is combinational from the vga inputs and registered slot state; it does not depend on registered vga inputs.
- A slot is drawn when it is valid, not collected, in PLAY, and its position matches the vga grid.
- Flag shape, with local offset (lx, ly):
  - Pole: lx in 5..7 and ly in 4..28.
  - Pennant: lx>7, ly in 4..16, and lx <= 26-(ly-4).
  - These constants are for CELL_LOG2=5. For other sizes they scale by a left shift of CELL_LOG2-5 (or a right shift of 5-CELL_LOG2).
- Blink: a `BLINK_LOG2`-bit counter on `frame_tick` toggles `blink_phase` when it wraps.
  - When `flags_left==1`, the remaining flag is drawn only while `blink_phase=1`.
  - `blink_phase` resets to 1 on `level_start`.
- `busy` = (state==LOAD).

## Timing
- Reset values:
  - state IDLE
  - `rom_addr=0`
  - `flag_pixel=0`
  - `collect_pulse=0`
  - `flags_left=0`
  - `all_collected=0`
  - `busy=0`
  - `blink_phase=1`
  - all slot registers cleared
- `level_start` at cycle T: `busy=1` from T+1 to T+MAX_FLAGS+1. PLAY begins at T+MAX_FLAGS+2.
- Player enters a flag cell in cycle H:
  - `collected` and `flags_left` update at H+1;
  - `collect_pulse` is high at H+1;
  - `all_collected` rises at H+1 if that was the last flag.
- `flag_pixel` has 0-cycle latency from `vga_x`/`vga_y`. It goes low at H+1 for the collected flag.
- Priority, highest first: `rst`, then `level_start`, then collection. A hit in the same cycle as `level_start` is ignored.
- The `flags_left` width must hold MAX_FLAGS without wrap. No underflow is possible.

## Test plan
- Reset, then `level_start` with level=1, MAX_FLAGS=8, ROM valid at slots 0 and 1 with (18,11) and (7,2) -> `busy` high for 9 cycles, then `flags_left=2`, `all_collected=0`.
- Player at pixel (580,356), which is cell (18,11) -> `collect_pulse` high for 1 cycle, `flags_left=1`. `flag_pixel` at vga (581,356) goes low, and the (7,2) flag blinks with the `blink_phase` period.
- Player moves to (230,70), which is cell (7,2) -> `flags_left=0` and `all_collected=1`. It stays high while the player stays in the cell, with no further pulses.
- Two valid slots at the same cell (9,8) -> a single hit cycle gives `flags_left` 2→0 and one `collect_pulse`.
- `level_start` pulsed mid-LOAD, at load cycle 4 -> the load restarts from slot 0, and the final `flags_left` reflects only the new level.
- Level with all ROM entries invalid -> PLAY with `flags_left=0`, `all_collected=0`, `flag_pixel=0` everywhere.
